invaders_memmap: RTL and testbench
==================================

INVADERS_MEMMAP -- requirements
Module: invaders_memmap

Interface
REQ-001 SHALL provide parameter ROM_BANKS, default 2, number of 8 KiB program ROM banks, range 1..4.
REQ-002 SHALL provide parameter VRAM_AW, default 13, video RAM address width.
REQ-003 SHALL provide parameter CRAM_AW, default 11, colour RAM/PROM address width.
REQ-004 SHALL provide parameter LOOKAHEAD, default 1, video read-ahead offset, range 1..3.
REQ-005 SHALL provide ports (name direction width meaning): Clock in 1 system clock; Reset_n in 1 reset, asynchronous, active-low.
REQ-006 SHALL provide ports dn_addr in 16, dn_data in 8, dn_wr in 1, dn_done in 1: ROM download bus and end-of-download level.
REQ-007 SHALL provide ports Addr in 16, CPU_RW_n in 1, Cpu_rd in 1, Cpu_in in 8: CPU address, write strobe (low), read request, write data.
REQ-008 SHALL provide ports Rom_out out 8, Rom_valid out 1: registered CPU read data and its one-cycle valid pulse.
REQ-009 SHALL provide ports Ram_Addr in 16, RW_n in 1, Ram_in in 8, Ram_out out 8, Next_byte out 8: video RAM port and read-ahead byte.
REQ-010 SHALL provide ports color_prom_addr in CRAM_AW, color_prom_out out 8: video-side colour lookup.
REQ-011 SHALL provide ports scramble_mode in 2 (0 none, 1 vortex, 2 attackforce), color_mode in 2 (0 direct, 1 swap bits 1/2, 2 invert), cram_window in 2 (0 none, 1 5C00-5FFF, 2 C000-DFFF).
REQ-012 SHALL provide ports Busy out 1, Loaded out 1, Checksum out 8: clear-in-progress, download complete, XOR of downloaded bytes.

Function
REQ-013 SHALL implement states CLEAR, IDLE, LOAD, READY; reset enters CLEAR.
REQ-014 CLEAR SHALL write 0 to every video RAM location, one per clock, 2^VRAM_AW cycles, then go to IDLE; Busy=1 only in CLEAR.
REQ-015 IDLE SHALL go to LOAD on first dn_wr; LOAD SHALL go to READY on dn_done=1; Loaded=1 only in READY.
REQ-016 dn_wr SHALL be accepted only in IDLE/LOAD; in READY downloads are ignored (write protect) and Checksum holds.
REQ-017 Download decode: dn_addr[15:13]=k<ROM_BANKS writes bank k; dn_addr[15:13]=ROM_BANKS with dn_addr[12:CRAM_AW]=0 writes colour RAM; other addresses discarded, not checksummed.
REQ-018 Checksum SHALL XOR each accepted dn_data into itself in the cycle after dn_wr.
REQ-019 Effective CPU address SHALL be Addr (mode 0), Addr with bits 9,3,0 inverted (mode 1), or Addr with bits 9 and 8 swapped (mode 2); mode 3 behaves as mode 0.
REQ-020 CPU read: Addr[15:14]=k<ROM_BANKS and Addr[13]=0 returns bank k; open colour window returns colour RAM; all else returns 0x00.
REQ-021 Rom_out SHALL update and Rom_valid pulse exactly one clock after Cpu_rd=1; back-to-back Cpu_rd SHALL produce back-to-back valid pulses.
REQ-022 Colour window 1 maps Addr[9:0]; window 2 maps {Addr[12:8],Addr[4:0]}; CPU writes (CPU_RW_n=0) in the window write Cpu_in; writes to ROM ranges are ignored.
REQ-023 Download write and CPU colour write in the same cycle: download wins, CPU write dropped.
REQ-024 color_prom_out SHALL be one-cycle registered and transformed per color_mode after read.
REQ-025 Video RAM: RW_n=0 writes Ram_in at Ram_Addr[VRAM_AW-1:0]; Ram_out one-cycle latency; writes ignored during CLEAR, Ram_out=0 during CLEAR.
REQ-026 Next_byte SHALL equal video RAM at (Ram_Addr+LOOKAHEAD) mod 2^VRAM_AW, one-cycle latency, wrapping at top.

Reset
REQ-027 Reset_n low SHALL asynchronously set state CLEAR, clear counter 0, Rom_out 0, Rom_valid 0, Checksum 0, Loaded 0, Busy 1, Ram_out 0, Next_byte 0, color_prom_out 0.
REQ-028 Reset mid-LOAD SHALL restart from CLEAR; ROM/colour contents need not be cleared.

Structure
REQ-029 State enum, scramble/colour mode encodings and region constants SHALL live in shared package invaders_pkg.
REQ-030 ROM banks SHALL use a generate loop of one sub-module, invaders_rom_bank (8 KiB dual-port RAM); video/colour RAMs reuse dpram.

Verification
REQ-031 Reset release -> Busy=1 for exactly 8192 cycles (VRAM_AW=13), then Busy=0; all Ram_out reads 0x00.
REQ-032 Download 0xA5 at 0x0000, 0x3C at 0x2000, dn_done -> Checksum=0x99, Loaded=1; Cpu_rd at 0x4000 -> Rom_out=0x3C one clock later, Rom_valid one-cycle pulse.
REQ-033 In READY, dn_wr 0xFF at 0x0000 -> Cpu_rd 0x0000 still returns 0xA5, Checksum unchanged.
REQ-034 cram_window=1, CPU writes 0x5A at 0x5C10 -> Cpu_rd 0x5C10 returns 0x5A; color_mode=1 lookup of 0x010 -> color_prom_out=0x5C.
REQ-035 Write 0x77 at video 0x1FFF, 0x11 at 0x0000, Ram_Addr=0x1FFF, LOOKAHEAD=1 -> Ram_out=0x77, Next_byte=0x11.
REQ-036 Reset asserted mid-LOAD -> Checksum=0, Loaded=0, Busy=1 immediately.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared types and constants for the invaders memory map:
// controller states, mode encodings, decode tags and address helpers.
package invaders_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_READY
    } state_e;

    typedef enum logic [1:0] {
        SCR_NONE,
        SCR_VORTEX,
        SCR_ATTACK,
        SCR_RSVD
    } scramble_e;

    typedef enum logic [1:0] {
        COL_DIRECT,
        COL_SWAP12,
        COL_INVERT,
        COL_RSVD
    } color_e;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_5C00,
        WIN_C000,
        WIN_RSVD
    } window_e;

    localparam int          BANK_AW     = 13;
    localparam logic [5:0]  WIN1_TAG    = 6'h17;   // 5C00-5FFF
    localparam logic [2:0]  WIN2_TAG    = 3'b110;  // C000-DFFF
    localparam logic [15:0] VORTEX_MASK = 16'h0209;

    function automatic logic [15:0] scramble_addr(
        input logic [15:0] a,
        input logic [1:0]  mode
    );
        logic [15:0] r;
        r = a;
        case (scramble_e'(mode))
            SCR_VORTEX: r = a ^ VORTEX_MASK;
            SCR_ATTACK: r = {a[15:10], a[8], a[9], a[7:0]};
            default:    r = a;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] color_xform(
        input logic [7:0] d,
        input logic [1:0] mode
    );
        logic [7:0] r;
        r = d;
        case (color_e'(mode))
            COL_SWAP12: r = {d[7:3], d[1], d[2], d[0]};
            COL_INVERT: r = ~d;
            default:    r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dpram.sv
// Generic RAM: one synchronous write port, two asynchronous read ports.
// Read data is registered by the user so each port sees one-cycle latency.
module dpram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/invaders_rom_bank.sv
// One 8 KiB program ROM bank: written by the download bus,
// read by the CPU through a separate port.
module invaders_rom_bank
    import invaders_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [BANK_AW-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic [BANK_AW-1:0] raddr,
    output logic [7:0]         rdata
);

    logic [7:0] mem [2**BANK_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/invaders_memmap.sv
// Invaders-style memory map: ROM download with checksum and write protect,
// scrambled CPU decode, colour RAM window, cleared video RAM with read-ahead.
module invaders_memmap
    import invaders_pkg::*;
#(
    parameter int ROM_BANKS = 2,
    parameter int VRAM_AW   = 13,
    parameter int CRAM_AW   = 11,
    parameter int LOOKAHEAD = 1
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [15:0]        dn_addr,
    input  logic [7:0]         dn_data,
    input  logic               dn_wr,
    input  logic               dn_done,
    input  logic [15:0]        Addr,
    input  logic               CPU_RW_n,
    input  logic               Cpu_rd,
    input  logic [7:0]         Cpu_in,
    output logic [7:0]         Rom_out,
    output logic               Rom_valid,
    input  logic [15:0]        Ram_Addr,
    input  logic               RW_n,
    input  logic [7:0]         Ram_in,
    output logic [7:0]         Ram_out,
    output logic [7:0]         Next_byte,
    input  logic [CRAM_AW-1:0] color_prom_addr,
    output logic [7:0]         color_prom_out,
    input  logic [1:0]         scramble_mode,
    input  logic [1:0]         color_mode,
    input  logic [1:0]         cram_window,
    output logic               Busy,
    output logic               Loaded,
    output logic [7:0]         Checksum
);

    localparam logic [2:0] NB = 3'(ROM_BANKS);

    state_e             state_q, state_d;
    logic [VRAM_AW-1:0] clr_q, clr_d;
    logic [7:0]         chk_q, chk_d;
    logic [7:0]         rom_q, rom_d;
    logic               rv_q, rv_d;
    logic [7:0]         ram_q, ram_d;
    logic [7:0]         nxt_q, nxt_d;
    logic [7:0]         cpo_q, cpo_d;

    logic               clearing;
    logic               dl_acc, dl_rom, dl_cram;
    logic [15:0]        ea;
    logic               win_hit, rom_hit;
    logic [CRAM_AW-1:0] win_addr;
    logic               cpu_cw;
    logic               cram_we;
    logic [CRAM_AW-1:0] cram_wa;
    logic [7:0]         cram_wd;
    logic [7:0]         cram_rd_cpu, cram_rd_vid;
    logic               vram_we;
    logic [VRAM_AW-1:0] vram_wa, vram_nxt;
    logic [7:0]         vram_wd;
    logic [7:0]         vram_rd, vram_rd_nxt;
    logic [7:0]         rom_rd [ROM_BANKS];
    logic [7:0]         rom_sel;
    logic               unused_ram_hi;

    assign unused_ram_hi = ^Ram_Addr[15:VRAM_AW];

    assign clearing = (state_q == ST_CLEAR);
    assign dl_acc   = dn_wr && (state_q == ST_IDLE || state_q == ST_LOAD);
    assign dl_rom   = dl_acc && (dn_addr[15:13] < NB);
    assign dl_cram  = dl_acc && (dn_addr[15:13] == NB)
                    && (dn_addr[12:CRAM_AW] == '0);

    assign ea = scramble_addr(Addr, scramble_mode);

    always_comb begin
        win_hit  = 1'b0;
        win_addr = '0;
        case (window_e'(cram_window))
            WIN_5C00: begin
                win_hit  = (ea[15:10] == WIN1_TAG);
                win_addr = CRAM_AW'(ea[9:0]);
            end
            WIN_C000: begin
                win_hit  = (ea[15:13] == WIN2_TAG);
                win_addr = CRAM_AW'({ea[12:8], ea[4:0]});
            end
            default: ;
        endcase
    end

    assign rom_hit = !ea[13] && ({1'b0, ea[15:14]} < NB);

    // A download to colour RAM takes the single write port over the CPU
    assign cpu_cw  = !CPU_RW_n && win_hit && !dl_cram;
    assign cram_we = dl_cram || cpu_cw;
    assign cram_wa = dl_cram ? dn_addr[CRAM_AW-1:0] : win_addr;
    assign cram_wd = dl_cram ? dn_data : Cpu_in;

    for (genvar k = 0; k < ROM_BANKS; k++) begin : g_bank
        invaders_rom_bank u_bank (
            .clk   (Clock),
            .we    (dl_rom && (dn_addr[15:13] == 3'(k))),
            .waddr (dn_addr[12:0]),
            .wdata (dn_data),
            .raddr (ea[12:0]),
            .rdata (rom_rd[k])
        );
    end

    dpram #(.AW(CRAM_AW), .DW(8)) u_cram (
        .clk     (Clock),
        .we      (cram_we),
        .waddr   (cram_wa),
        .wdata   (cram_wd),
        .raddr_a (win_addr),
        .rdata_a (cram_rd_cpu),
        .raddr_b (color_prom_addr),
        .rdata_b (cram_rd_vid)
    );

    assign vram_we  = clearing || !RW_n;
    assign vram_wa  = clearing ? clr_q : Ram_Addr[VRAM_AW-1:0];
    assign vram_wd  = clearing ? 8'h00 : Ram_in;
    assign vram_nxt = Ram_Addr[VRAM_AW-1:0] + VRAM_AW'(LOOKAHEAD);

    dpram #(.AW(VRAM_AW), .DW(8)) u_vram (
        .clk     (Clock),
        .we      (vram_we),
        .waddr   (vram_wa),
        .wdata   (vram_wd),
        .raddr_a (Ram_Addr[VRAM_AW-1:0]),
        .rdata_a (vram_rd),
        .raddr_b (vram_nxt),
        .rdata_b (vram_rd_nxt)
    );

    always_comb begin
        rom_sel = 8'h00;
        for (int k = 0; k < ROM_BANKS; k++) begin
            if (ea[15:14] == 2'(k)) begin
                rom_sel = rom_rd[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        chk_d   = chk_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (dn_wr) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (dn_done) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: ;
        endcase
        if (dl_rom || dl_cram) begin
            chk_d = chk_q ^ dn_data;
        end
    end

    always_comb begin
        rom_d = rom_q;
        rv_d  = Cpu_rd;
        if (Cpu_rd) begin
            if (win_hit) begin
                rom_d = cram_rd_cpu;
            end else if (rom_hit) begin
                rom_d = rom_sel;
            end else begin
                rom_d = 8'h00;
            end
        end
        ram_d = clearing ? 8'h00 : vram_rd;
        nxt_d = clearing ? 8'h00 : vram_rd_nxt;
        cpo_d = color_xform(cram_rd_vid, color_mode);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
            chk_q   <= 8'h00;
            rom_q   <= 8'h00;
            rv_q    <= 1'b0;
            ram_q   <= 8'h00;
            nxt_q   <= 8'h00;
            cpo_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            chk_q   <= chk_d;
            rom_q   <= rom_d;
            rv_q    <= rv_d;
            ram_q   <= ram_d;
            nxt_q   <= nxt_d;
            cpo_q   <= cpo_d;
        end
    end

    assign Busy           = clearing;
    assign Loaded         = (state_q == ST_READY);
    assign Checksum       = chk_q;
    assign Rom_out        = rom_q;
    assign Rom_valid      = rv_q;
    assign Ram_out        = ram_q;
    assign Next_byte      = nxt_q;
    assign color_prom_out = cpo_q;

endmodule

// File: tb/tb_invaders_memmap.sv
// Bench for invaders_memmap: CPU reads go through an expected-value
// queue drained by a monitor on Rom_valid; other outputs checked inline.
module tb_invaders_memmap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr, dn_done;
    logic [15:0] Addr;
    logic        CPU_RW_n, Cpu_rd;
    logic [7:0]  Cpu_in;
    logic [7:0]  Rom_out;
    logic        Rom_valid;
    logic [15:0] Ram_Addr;
    logic        RW_n;
    logic [7:0]  Ram_in, Ram_out, Next_byte;
    logic [10:0] color_prom_addr;
    logic [7:0]  color_prom_out;
    logic [1:0]  scramble_mode, color_mode, cram_window;
    logic        Busy, Loaded;
    logic [7:0]  Checksum;

    int n_chk = 0;
    int n_fail = 0;
    int n_reads = 0;
    int n_valid = 0;
    logic [7:0] exp_q[$];
    string      nm_q[$];

    invaders_memmap dut (
        .Clock           (clk),
        .Reset_n         (rst_n),
        .dn_addr         (dn_addr),
        .dn_data         (dn_data),
        .dn_wr           (dn_wr),
        .dn_done         (dn_done),
        .Addr            (Addr),
        .CPU_RW_n        (CPU_RW_n),
        .Cpu_rd          (Cpu_rd),
        .Cpu_in          (Cpu_in),
        .Rom_out         (Rom_out),
        .Rom_valid       (Rom_valid),
        .Ram_Addr        (Ram_Addr),
        .RW_n            (RW_n),
        .Ram_in          (Ram_in),
        .Ram_out         (Ram_out),
        .Next_byte       (Next_byte),
        .color_prom_addr (color_prom_addr),
        .color_prom_out  (color_prom_out),
        .scramble_mode   (scramble_mode),
        .color_mode      (color_mode),
        .cram_window     (cram_window),
        .Busy            (Busy),
        .Loaded          (Loaded),
        .Checksum        (Checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && Rom_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rom_unexpected: got %0h, none expected",
                         Rom_out);
            end else begin
                chk(nm_q.pop_front(), {24'h0, Rom_out},
                    {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e,
                      input string nm);
        Addr   = a;
        Cpu_rd = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        n_reads++;
        cyc();
        Cpu_rd = 1'b0;
    endtask

    task automatic dl(input logic [15:0] a, input logic [7:0] d);
        dn_addr = a;
        dn_data = d;
        dn_wr   = 1'b1;
        cyc();
        dn_wr   = 1'b0;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        Addr     = a;
        Cpu_in   = d;
        CPU_RW_n = 1'b0;
        cyc();
        CPU_RW_n = 1'b1;
    endtask

    task automatic vid_wr(input logic [15:0] a, input logic [7:0] d);
        Ram_Addr = a;
        Ram_in   = d;
        RW_n     = 1'b0;
        cyc();
        RW_n     = 1'b1;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b1;
        dn_addr = '0; dn_data = '0; dn_wr = 1'b0; dn_done = 1'b0;
        Addr = '0; CPU_RW_n = 1'b1; Cpu_rd = 1'b0; Cpu_in = '0;
        Ram_Addr = '0; RW_n = 1'b1; Ram_in = '0;
        color_prom_addr = '0;
        scramble_mode = 2'd0; color_mode = 2'd0; cram_window = 2'd0;
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", {31'h0, Busy}, 1);
        chk("rst_loaded", {31'h0, Loaded}, 0);
        chk("rst_checksum", {24'h0, Checksum}, 0);
        chk("rst_rom_valid", {31'h0, Rom_valid}, 0);
        chk("rst_ram_out", {24'h0, Ram_out}, 0);

        // video writes attempted through the whole clear must be dropped
        Ram_Addr = 16'h0000;
        Ram_in   = 8'h33;
        RW_n     = 1'b0;
        rst_n    = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (Busy !== 1'b1) break;
            cnt++;
            if (i == 100) chk("clear_ram_out", {24'h0, Ram_out}, 0);
        end
        RW_n = 1'b1;
        chk("busy_cycles", cnt, 8192);
        chk("idle_loaded", {31'h0, Loaded}, 0);
        cyc();
        chk("clr_ram0", {24'h0, Ram_out}, 0);
        chk("clr_nxt0", {24'h0, Next_byte}, 0);
        Ram_Addr = 16'h1000;
        cyc();
        chk("clr_ram1000", {24'h0, Ram_out}, 0);

        dl(16'h0000, 8'hA5);
        dl(16'h2000, 8'h3C);
        chk("csum_two", {24'h0, Checksum}, 8'h99);
        chk("load_loaded", {31'h0, Loaded}, 0);
        dl(16'hE000, 8'h0F);
        chk("csum_discard", {24'h0, Checksum}, 8'h99);
        // colour download collides with a CPU colour write
        cram_window = 2'd1;
        Addr     = 16'h5C05;
        Cpu_in   = 8'h99;
        CPU_RW_n = 1'b0;
        dl(16'h4005, 8'h42);
        CPU_RW_n = 1'b1;
        chk("csum_cram", {24'h0, Checksum}, 8'hDB);
        dl(16'h4805, 8'h55);
        chk("csum_cram_discard", {24'h0, Checksum}, 8'hDB);
        dn_done = 1'b1;
        cyc();
        dn_done = 1'b0;
        chk("ready_loaded", {31'h0, Loaded}, 1);

        rd(16'h4000, 8'h3C, "rd_bank1");
        cyc();
        chk("valid_pulse_end", {31'h0, Rom_valid}, 0);
        rd(16'h0000, 8'hA5, "rd_b2b_0");
        rd(16'h4000, 8'h3C, "rd_b2b_1");
        rd(16'h2000, 8'h00, "rd_gap");
        rd(16'h8000, 8'h00, "rd_nobank");
        rd(16'h5C05, 8'h42, "rd_cram_collide");

        dl(16'h0000, 8'hFF);
        chk("wp_checksum", {24'h0, Checksum}, 8'hDB);
        rd(16'h0000, 8'hA5, "rd_wp");

        cpu_wr(16'h5C10, 8'h5A);
        cpu_wr(16'h4000, 8'hEE);
        rd(16'h5C10, 8'h5A, "rd_win1");
        rd(16'h4000, 8'h3C, "rd_rom_cpu_wr");
        color_prom_addr = 11'h010;
        color_mode = 2'd1;
        cyc();
        chk("cprom_swap", {24'h0, color_prom_out}, 8'h5C);
        color_mode = 2'd2;
        cyc();
        chk("cprom_inv", {24'h0, color_prom_out}, 8'hA5);
        color_mode = 2'd0;
        color_prom_addr = 11'h005;
        cyc();
        chk("cprom_direct", {24'h0, color_prom_out}, 8'h42);

        cram_window = 2'd2;
        cpu_wr(16'hC105, 8'h66);
        rd(16'hC105, 8'h66, "rd_win2");
        color_prom_addr = 11'h025;
        cyc();
        chk("cprom_win2", {24'h0, color_prom_out}, 8'h66);
        cram_window = 2'd0;
        rd(16'hC105, 8'h00, "rd_win_closed");

        scramble_mode = 2'd1;
        rd(16'h4209, 8'h3C, "rd_vortex");
        scramble_mode = 2'd2;
        cram_window = 2'd1;
        cpu_wr(16'h5E10, 8'h24);
        scramble_mode = 2'd0;
        rd(16'h5D10, 8'h24, "rd_attack_swap");
        scramble_mode = 2'd3;
        rd(16'h4000, 8'h3C, "rd_mode3");
        scramble_mode = 2'd0;

        vid_wr(16'h1FFF, 8'h77);
        vid_wr(16'h0000, 8'h11);
        Ram_Addr = 16'h1FFF;
        cyc();
        chk("vram_top", {24'h0, Ram_out}, 8'h77);
        chk("vram_wrap_next", {24'h0, Next_byte}, 8'h11);
        Ram_Addr = 16'h1FFE;
        cyc();
        chk("vram_1ffe", {24'h0, Ram_out}, 8'h00);
        chk("vram_next_1fff", {24'h0, Next_byte}, 8'h77);

        cyc();
        cyc();
        chk("sb_empty", exp_q.size(), 0);
        chk("valid_count", n_valid, n_reads);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 10000) begin
            cyc();
            cnt++;
        end
        chk("busy2_done", {31'h0, Busy}, 0);
        dl(16'h0010, 8'h5A);
        chk("load2_checksum", {24'h0, Checksum}, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("midload_checksum", {24'h0, Checksum}, 0);
        chk("midload_loaded", {31'h0, Loaded}, 0);
        chk("midload_busy", {31'h0, Busy}, 1);
        chk("midload_cprom", {24'h0, color_prom_out}, 0);
        chk("midload_rom_out", {24'h0, Rom_out}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
